// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 slave: mode constants, default widths
// and the frame FSM encoding.
package spi_pkg;

  localparam int CPOL = 0;
  localparam int CPHA = 0;

  localparam int         DEFAULT_DATA_W    = 8;
  localparam logic [7:0] DEFAULT_IDLE_WORD = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus one history flop; reports the synchronized
// level together with single-cycle rise and fall strobes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave endpoint, oversampled in the clk_i domain, with a
// single-entry TX buffer. Define SPI_SLAVE_OVERRUN_EN to add rx_overrun_o.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int                DATA_W      = DEFAULT_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(DEFAULT_IDLE_WORD)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ack_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_ready_o,
`ifdef SPI_SLAVE_OVERRUN_EN
  output logic              rx_overrun_o,
`endif
  output logic              busy_o
);

  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_reg_q, rx_shift_q, tx_buf_q;
  logic              tx_full_q, word_done_q, armed_q;
  logic [FLUSH_W-1:0] flush_cnt_q;

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic cs_start, load_now, flushed;
  logic [DATA_W-1:0] reload_word;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sclk_i),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_cs_i),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_mosi_i),
    .level_o(mosi_level), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  // A frame may only start after CS has been seen high through a flushed
  // synchronizer, so a CS held low across reset never opens a frame.
  assign flushed = (flush_cnt_q == FLUSH_W'(SYNC_STAGES + 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else if (!flushed) begin
      flush_cnt_q <= flush_cnt_q + 1'b1;
    end else if (cs_level) begin
      armed_q <= 1'b1;
    end
  end

  assign cs_start    = cs_fall & armed_q;
  assign reload_word = tx_full_q ? tx_buf_q : IDLE_WORD;
  assign load_now    = ((state_q == IDLE) && cs_start) ||
                       ((state_q == SHIFT) && sclk_fall && (bit_cnt_q == CNT_W'(DATA_W)));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_start) state_d = SHIFT;
      SHIFT:   if (cs_rise)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q == SHIFT);
    spi_miso_oe_o = (state_q == SHIFT);
    spi_miso_o    = (state_q == SHIFT) ? shift_reg_q[DATA_W-1] : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_reg_q <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      if (load_now) begin
        shift_reg_q <= reload_word;
        bit_cnt_q   <= '0;
      end else if (state_q == SHIFT) begin
        if (sclk_rise) begin
          rx_shift_q  <= {rx_shift_q[DATA_W-2:0], mosi_level};
          bit_cnt_q   <= bit_cnt_q + 1'b1;
          word_done_q <= (bit_cnt_q == CNT_W'(DATA_W - 1));
        end else if (sclk_fall) begin
          shift_reg_q <= {shift_reg_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // A reload empties the buffer; a load accepted in the same cycle refills it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_full_q <= 1'b0;
      tx_buf_q  <= '0;
    end else begin
      if (load_now) tx_full_q <= 1'b0;
      if (tx_load_i && !tx_full_q) begin
        tx_buf_q  <= tx_data_i;
        tx_full_q <= 1'b1;
      end
    end
  end

  assign tx_ready_o = ~tx_full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else if (word_done_q) begin
      rx_data_o  <= rx_shift_q;
      rx_valid_o <= 1'b1;
    end else if (rx_ack_i) begin
      rx_valid_o <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                 rx_overrun_o <= 1'b0;
    else if (rx_ack_i)                         rx_overrun_o <= 1'b0;
    else if (word_done_q && rx_valid_o)        rx_overrun_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: bit-banged SPI master with fixed timing
// and hand-computed expectations; rx_overrun_o checked under SPI_SLAVE_OVERRUN_EN.
module tb_spi_slave_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready, busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_overrun;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] miso_a, miso_b;

  always #5 clk = ~clk;

  spi_slave_core dut (
    .clk_i(clk), .rst_i(rst),
    .spi_sclk_i(spi_sclk), .spi_cs_i(spi_cs), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso), .spi_miso_oe_o(spi_miso_oe),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ack_i(rx_ack),
    .tx_data_i(tx_data), .tx_load_i(tx_load), .tx_ready_o(tx_ready),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_overrun_o(rx_overrun),
`endif
    .busy_o(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts nbits of mosi_byte MSB-first with 8-cycle SCLK phases, sampling MISO
  // just before each rising edge; optionally acks in the cycle the word lands.
  task automatic applyStimulus(input logic [7:0] mosi_byte, input int nbits,
                               input bit ack_last, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_byte[7-i];
      waitCycles(8);
      miso_byte[7-i] = spi_miso;
      spi_sclk = 1'b1;
      if (ack_last && (i == nbits - 1)) begin
        waitCycles(3);
        rx_ack = 1'b1;
        waitCycles(1);
        rx_ack = 1'b0;
        waitCycles(4);
      end else begin
        waitCycles(8);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic pulseAck();
    rx_ack = 1'b1;
    waitCycles(1);
    rx_ack = 1'b0;
    waitCycles(1);
  endtask

  task automatic loadTx(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    waitCycles(1);
    tx_load = 1'b0;
    waitCycles(1);
  endtask

  initial begin
    // Reset state
    waitCycles(3);
    checkOutput("rst_miso", spi_miso, 1);
    checkOutput("rst_oe", spi_miso_oe, 0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    waitCycles(10);

    // 0xA5 with empty TX buffer: MISO returns idle word
    spi_cs = 1'b0;
    waitCycles(8);
    checkOutput("f1_busy", busy, 1);
    checkOutput("f1_oe", spi_miso_oe, 1);
    applyStimulus(8'hA5, 8, 1'b0, miso_a);
    waitCycles(4);
    spi_cs = 1'b1;
    waitCycles(8);
    checkOutput("f1_rx_valid", rx_valid, 1);
    checkOutput("f1_rx_data", rx_data, 8'hA5);
    checkOutput("f1_miso", miso_a, 8'hFF);
    checkOutput("f1_tx_ready", tx_ready, 1);
    checkOutput("f1_busy_end", busy, 0);
    checkOutput("f1_oe_end", spi_miso_oe, 0);
    checkOutput("f1_miso_idle", spi_miso, 1);
    pulseAck();
    checkOutput("f1_ack_clears", rx_valid, 0);

    // Preloaded 0x3C, second load while full is dropped
    loadTx(8'h3C);
    checkOutput("f2_tx_full", tx_ready, 0);
    loadTx(8'h99);
    spi_cs = 1'b0;
    waitCycles(8);
    checkOutput("f2_tx_ready_after_cs", tx_ready, 1);
    applyStimulus(8'h00, 8, 1'b0, miso_a);
    waitCycles(4);
    spi_cs = 1'b1;
    waitCycles(8);
    checkOutput("f2_miso", miso_a, 8'h3C);
    checkOutput("f2_rx_data", rx_data, 8'h00);
    checkOutput("f2_rx_valid", rx_valid, 1);
    pulseAck();

    // Two words without ack; TX loaded during word 1
    spi_cs = 1'b0;
    waitCycles(8);
    loadTx(8'h55);
    applyStimulus(8'h12, 8, 1'b0, miso_a);
    checkOutput("f3_w1_rx_data", rx_data, 8'h12);
    applyStimulus(8'h34, 8, 1'b0, miso_b);
    waitCycles(4);
    spi_cs = 1'b1;
    waitCycles(8);
    checkOutput("f3_w1_miso", miso_a, 8'hFF);
    checkOutput("f3_w2_miso", miso_b, 8'h55);
    checkOutput("f3_rx_data", rx_data, 8'h34);
    checkOutput("f3_rx_valid", rx_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
    checkOutput("f3_overrun_set", rx_overrun, 1);
    waitCycles(5);
    checkOutput("f3_overrun_sticky", rx_overrun, 1);
`endif
    pulseAck();
    checkOutput("f3_ack_clears", rx_valid, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
    checkOutput("f3_overrun_cleared", rx_overrun, 0);
`endif

    // Partial frame discarded, then a clean 0x81
    spi_cs = 1'b0;
    waitCycles(8);
    applyStimulus(8'hF8, 5, 1'b0, miso_a);
    spi_cs = 1'b1;
    waitCycles(12);
    checkOutput("f4_partial_no_valid", rx_valid, 0);
    checkOutput("f4_partial_rx_data", rx_data, 8'h34);
    spi_cs = 1'b0;
    waitCycles(8);
    applyStimulus(8'h81, 8, 1'b0, miso_a);
    waitCycles(4);
    spi_cs = 1'b1;
    waitCycles(8);
    checkOutput("f4_rx_data", rx_data, 8'h81);
    checkOutput("f4_rx_valid", rx_valid, 1);

    // Ack lands in the completion cycle of 0x7E while 0x81 is pending
    spi_cs = 1'b0;
    waitCycles(8);
    applyStimulus(8'h7E, 8, 1'b1, miso_a);
    waitCycles(4);
    spi_cs = 1'b1;
    waitCycles(8);
    checkOutput("f5_rx_valid", rx_valid, 1);
    checkOutput("f5_rx_data", rx_data, 8'h7E);
`ifdef SPI_SLAVE_OVERRUN_EN
    checkOutput("f5_no_overrun", rx_overrun, 0);
`endif
    pulseAck();

    // Reset at bit 3 with a word in the TX buffer
    spi_cs = 1'b0;
    waitCycles(8);
    loadTx(8'hAB);
    applyStimulus(8'hE0, 3, 1'b0, miso_a);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("r_miso", spi_miso, 1);
    checkOutput("r_oe", spi_miso_oe, 0);
    checkOutput("r_rx_data", rx_data, 8'h00);
    checkOutput("r_rx_valid", rx_valid, 0);
    checkOutput("r_tx_ready", tx_ready, 1);
    checkOutput("r_busy", busy, 0);
    rst = 1'b0;
    waitCycles(2);
    applyStimulus(8'h5A, 8, 1'b0, miso_a);
    waitCycles(8);
    checkOutput("r_cs_low_no_capture", rx_valid, 0);
    checkOutput("r_cs_low_idle", busy, 0);
    spi_cs = 1'b1;
    waitCycles(10);
    spi_cs = 1'b0;
    waitCycles(8);
    applyStimulus(8'hC3, 8, 1'b0, miso_a);
    waitCycles(4);
    spi_cs = 1'b1;
    waitCycles(8);
    checkOutput("r_rx_data_c3", rx_data, 8'hC3);
    checkOutput("r_rx_valid_c3", rx_valid, 1);
    checkOutput("r_miso_c3", miso_a, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
